// File: rtl/nios_sd_in_pio.sv
// Avalon-MM edge-capturing input PIO for SD card-detect/DAT lines.
// Define NIOS_SD_IN_PIO_IRQ_EN to build the irqmask register and the irq output.
module nios_sd_in_pio #(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Bus handshake: a transfer happens on every rising clk edge where chipselect
  // is high and the matching active-low strobe is low; there is no wait state,
  // and readdata holds the result from the edge of the read strobe onwards.

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clear_bits;
  logic [WIDTH-1:0] mask_view;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic             read_en;
  logic             write_en;
  logic [31:0]      read_mux;
  logic             unused_wdata;

  assign read_en      = chipselect && !read_n;
  assign write_en     = chipselect && !write_n;
  assign armed        = (arm_cnt == 2'd3);
  assign unused_wdata = ^writedata;

  // prev starts at zero after reset, so capture waits until it holds real input history.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
      if (!armed) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    edge_hit = sync2 ^ prev;
    if (EDGE_TYPE == 0) begin
      edge_hit = sync2 & ~prev;
    end else if (EDGE_TYPE == 1) begin
      edge_hit = ~sync2 & prev;
    end
  end

  always_comb begin
    clear_bits = '0;
    if (write_en && (address == 2'd3)) begin
      clear_bits = writedata[WIDTH-1:0];
    end
  end

  // A fresh edge wins over a software clear landing on the same clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      edgecapture <= '0;
    end else begin
      edgecapture <= (edgecapture & ~clear_bits) | (edge_hit & {WIDTH{armed}});
    end
  end

`ifdef NIOS_SD_IN_PIO_IRQ_EN
  logic [WIDTH-1:0] irqmask;

  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask <= '0;
    end else if (write_en && (address == 2'd2)) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign mask_view = irqmask;
  assign irq       = |(edgecapture & irqmask);
`else
  assign mask_view = '0;
  assign irq       = 1'b0;
`endif

  always_comb begin
    read_mux = '0;
    case (address)
      2'd0:    read_mux[WIDTH-1:0] = sync2;
      2'd2:    read_mux[WIDTH-1:0] = mask_view;
      2'd3:    read_mux[WIDTH-1:0] = edgecapture;
      default: read_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (read_en) begin
      readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_nios_sd_in_pio.sv
// Bench for nios_sd_in_pio: three instances (rising, falling, any edge) share one bus,
// checked by directed tables/sequences and by random traffic against a history model.
module tb_nios_sd_in_pio;

  localparam int W = 4;
`ifdef NIOS_SD_IN_PIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [1:0]   address;
  logic         chipselect;
  logic         read_n;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  rdata [3];
  logic         irq_v [3];

  int n_vec = 0;
  int n_err = 0;

  nios_sd_in_pio #(.WIDTH(W), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rdata[0]), .in_port(in_port), .irq(irq_v[0]));
  nios_sd_in_pio #(.WIDTH(W), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rdata[1]), .in_port(in_port), .irq(irq_v[1]));
  nios_sd_in_pio #(.WIDTH(W), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(rdata[2]), .in_port(in_port), .irq(irq_v[2]));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // smp_q holds in_port as sampled at the most recent clocks (newest first);
  // software sees the sample from two clocks back, edges compare it with the one before.
  logic [W-1:0] smp_q [$];
  logic [W-1:0] m_ec [3];
  logic [W-1:0] m_mask;
  logic [31:0]  m_rd [3];
  int           m_since;
  logic [W-1:0] m_seen;
  logic [W-1:0] m_seen_old;
  logic [W-1:0] m_clr;

  function automatic logic [W-1:0] edges_of(int kind, logic [W-1:0] old_v, logic [W-1:0] new_v);
    if (kind == 0) return new_v & ~old_v;
    if (kind == 1) return ~new_v & old_v;
    return new_v ^ old_v;
  endfunction

  function automatic logic [31:0] model_view(int k, logic [1:0] a, logic [W-1:0] seen);
    case (a)
      2'd0:    return 32'(seen);
      2'd2:    return IRQ_EN ? 32'(m_mask) : 32'd0;
      2'd3:    return 32'(m_ec[k]);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_irq(int k);
    return IRQ_EN && (|(m_ec[k] & m_mask));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      smp_q.delete();
      repeat (3) smp_q.push_back('0);
      m_mask  = '0;
      m_since = 0;
      for (int k = 0; k < 3; k++) begin
        m_ec[k] = '0;
        m_rd[k] = '0;
      end
    end else begin
      m_seen     = smp_q[1];
      m_seen_old = smp_q[2];
      m_clr      = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int k = 0; k < 3; k++) begin
        if (chipselect && !read_n) m_rd[k] = model_view(k, address, m_seen);
      end
      for (int k = 0; k < 3; k++) begin
        m_ec[k] = (m_ec[k] & ~m_clr) |
                  ((m_since >= 3) ? edges_of(k, m_seen_old, m_seen) : '0);
      end
      if (IRQ_EN && chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      smp_q.push_front(in_port);
      void'(smp_q.pop_back());
      if (m_since < 3) m_since++;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_rd3(input string tag, input logic [31:0] er, input logic [31:0] ef,
                           input logic [31:0] ea);
    check({tag, "_rd_rise"}, rdata[0], er);
    check({tag, "_rd_fall"}, rdata[1], ef);
    check({tag, "_rd_any"},  rdata[2], ea);
  endtask

  task automatic check_irq3(input string tag, input logic er, input logic ef, input logic ea);
    check({tag, "_irq_rise"}, 32'(irq_v[0]), 32'(er));
    check({tag, "_irq_fall"}, 32'(irq_v[1]), 32'(ef));
    check({tag, "_irq_any"},  32'(irq_v[2]), 32'(ea));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_bus();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = a;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    idle_bus();
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp_r;
    logic [31:0] exp_f;
    logic [31:0] exp_a;
  } rd_vec_t;

  rd_vec_t arm_tbl [4];
  rd_vec_t rst_tbl [4];

  initial begin
    arm_tbl[0] = '{2'd0, 32'hA, 32'hA, 32'hA};
    arm_tbl[1] = '{2'd1, 32'h0, 32'h0, 32'h0};
    arm_tbl[2] = '{2'd2, 32'h0, 32'h0, 32'h0};
    arm_tbl[3] = '{2'd3, 32'h0, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) rst_tbl[i] = '{2'(i), 32'h0, 32'h0, 32'h0};

    idle_bus();
    in_port = 4'hA;
    reset   = 1'b1;
    step(2);
    check_rd3("reset", 32'h0, 32'h0, 32'h0);
    check_irq3("reset", 1'b0, 1'b0, 1'b0);

    // input held across reset release: the 0->A change must not be captured
    reset = 1'b0;
    step(6);
    for (int i = 0; i < 4; i++) begin
      bus_read(arm_tbl[i].addr);
      check_rd3($sformatf("arm_a%0d", i), arm_tbl[i].exp_r, arm_tbl[i].exp_f, arm_tbl[i].exp_a);
    end

    // bit 0 rises, masked in, then cleared
    bus_write(2'd2, 32'h1);
    in_port = 4'hB;
    step(3);
    bus_read(2'd3);
    check_rd3("rise_ec", 32'h1, 32'h0, 32'h1);
    check_irq3("rise_irq", IRQ_EN, 1'b0, IRQ_EN);
    bus_write(2'd3, 32'h1);
    check_irq3("clr_irq", 1'b0, 1'b0, 1'b0);
    bus_read(2'd3);
    check_rd3("clr_ec", 32'h0, 32'h0, 32'h0);

    // bit 2 pulses high; its falling edge lands on the clock of a clear of bit 2
    in_port = 4'hF;
    step(1);
    in_port = 4'hB;
    step(2);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    check_rd3("setprio_ec", 32'h0, 32'h4, 32'h4);
    check_irq3("setprio_irq", 1'b0, 1'b0, 1'b0);

    // all bits fall with mask 0, then unmask bit 3
    in_port = 4'hF;
    step(5);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h0);
    in_port = 4'h0;
    step(3);
    bus_read(2'd3);
    check_rd3("fall_ec", 32'h0, 32'hF, 32'hF);
    check_irq3("fall_irq_m0", 1'b0, 1'b0, 1'b0);
    bus_write(2'd2, 32'h8);
    check_irq3("fall_irq_m8", 1'b0, IRQ_EN, IRQ_EN);
    bus_read(2'd2);
    check_rd3("mask_rd", IRQ_EN ? 32'h8 : 32'h0, IRQ_EN ? 32'h8 : 32'h0, IRQ_EN ? 32'h8 : 32'h0);

    // edgecapture=5 everywhere, mask F, then a one-clock reset with a read pending
    bus_write(2'd3, 32'hF);
    in_port = 4'h5;
    step(5);
    in_port = 4'h0;
    step(5);
    bus_write(2'd2, 32'hF);
    bus_read(2'd3);
    check_rd3("pre_rst_ec", 32'h5, 32'h5, 32'h5);
    check_irq3("pre_rst_irq", IRQ_EN, IRQ_EN, IRQ_EN);
    reset      = 1'b1;
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = 2'd3;
    step(1);
    reset = 1'b0;
    idle_bus();
    check_rd3("post_rst", 32'h0, 32'h0, 32'h0);
    check_irq3("post_rst", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus_read(rst_tbl[i].addr);
      check_rd3($sformatf("rst_a%0d", i), rst_tbl[i].exp_r, rst_tbl[i].exp_f, rst_tbl[i].exp_a);
    end

    // random traffic against the model
    for (int it = 0; it < 600; it++) begin
      int op;
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom_range(0, 15));
      op = $urandom_range(0, 19);
      if (op < 8) begin
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = 2'($urandom_range(0, 3));
      end else if (op < 14) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 2'($urandom_range(0, 3));
        writedata  = $urandom();
      end else if (op == 14) begin
        reset = 1'b1;
      end
      step(1);
      reset = 1'b0;
      idle_bus();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rnd%0d_rd%0d", it, k), rdata[k], m_rd[k]);
        check($sformatf("rnd%0d_irq%0d", it, k), 32'(irq_v[k]), 32'(model_irq(k)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios_sd_in_pio.md
NIOS_SD_IN_PIO -- requirements
Module: nios_sd_in_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the number of input port bits (1..32).
REQ-002 SHALL have parameter EDGE_TYPE, default 2, selecting the capture edge: 0 rising, 1 falling, 2 any.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port address  input  2  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  slave select.
REQ-007 SHALL have port read_n  input  1  active-low read strobe.
REQ-008 SHALL have port write_n  input  1  active-low write strobe.
REQ-009 SHALL have port writedata  input  32  write data.
REQ-010 SHALL have port readdata  output  32  registered read data.
REQ-011 SHALL have port in_port  input  WIDTH  asynchronous external inputs (SD card-detect/DAT lines).
REQ-012 SHALL have port irq  output  1  level interrupt, active-high.

Function
REQ-013 SHALL pass in_port through a 2-flop synchronizer (sync1, sync2); all other logic uses sync2 only.
REQ-014 SHALL hold prev = sync2 delayed by one clock; edge = sync2 & ~prev (type 0), ~sync2 & prev (1), sync2 ^ prev (2).
REQ-015 SHALL map registers: 0 data (RO, sync2), 1 reserved (reads 0, writes ignored), 2 irqmask (RW, WIDTH bits), 3 edgecapture (RW1C).
REQ-016 SHALL perform a read when chipselect && !read_n; readdata updates on that clock edge (1-cycle read latency); bits above WIDTH read 0.
REQ-017 SHALL hold readdata at its last value when no read is in progress.
REQ-018 SHALL perform a write when chipselect && !write_n; writes to address 0 or 1 have no effect.
REQ-019 SHALL on write to address 3 clear each edgecapture bit whose writedata bit is 1; 0 bits are left unchanged.
REQ-020 SHALL give set priority over clear: an edge detected in the same cycle as a clearing write leaves that bit set.
REQ-021 SHALL keep edgecapture bits sticky until cleared by software or reset.
REQ-022 SHALL drive irq = |(edgecapture & irqmask), combinationally from registered state.
REQ-023 SHALL make a change on in_port visible in data 2 clocks after the edge at which sync1 first samples it, and in edgecapture 3 clocks after that edge.
REQ-024 SHALL run an arming counter (0..3) that suppresses edge capture until 3 clocks after reset deasserts, so that reset-to-zero of prev yields no spurious edges.
REQ-025 SHALL return register 0 contents sampled in the same cycle as the read strobe when a read and an input change coincide; no stale/torn values beyond that cycle.

Reset
REQ-026 SHALL on reset clear sync1, sync2, prev, irqmask, edgecapture, readdata and the arming counter to 0; irq SHALL be 0 from the first clock after reset is sampled.
REQ-027 SHALL abort any read in progress when reset is asserted; readdata SHALL read 0 until the next read.
REQ-028 SHALL ignore reads and writes in any cycle with reset asserted.

Configuration
REQ-029 SHALL compile the irqmask register and irq logic only when macro NIOS_SD_IN_PIO_IRQ_EN is defined.
REQ-030 SHALL, without NIOS_SD_IN_PIO_IRQ_EN, tie irq to 0, read address 2 as 0 and ignore writes to it; edgecapture SHALL still operate.

Verification
REQ-031 SHALL verify: WIDTH=4, reset released, in_port=4'b1010 held -> read addr 0 returns 0x0000000A; edgecapture reads 0 (arming suppression).
REQ-032 SHALL verify: EDGE_TYPE=0, irqmask=0x1, in_port[0] 0->1 -> edgecapture=0x1 three clocks after sampling, irq=1; write 0x1 to addr 3 -> irq=0 next clock.
REQ-033 SHALL verify: EDGE_TYPE=2, edge on bit 2 in the same cycle as a clearing write of 0x4 to addr 3 -> edgecapture bit 2 remains 1.
REQ-034 SHALL verify: EDGE_TYPE=1, in_port 0xF->0x0, irqmask=0x0 -> edgecapture=0xF, irq=0; then write irqmask=0x8 -> irq=1.
REQ-035 SHALL verify: reset asserted for 1 clock with edgecapture=0x5, irqmask=0xF -> all registers read 0, irq=0; with macro undefined, irq stays 0 under any stimulus.
